polyveck_caddq_seq: RTL

Sequential conditional-add-Q stage for a K-polynomial vector. It maps each signed 32-bit coefficient from centered form, as produced by the vector reduction stage, to the standard representative in [0, Q). It sits downstream of the combinational vector reduce and feeds packing/encoding. Unlike the reduce path, it processes LANES coefficients per cycle under a start/busy/done handshake, which bounds adder count.

---
 rtl/polyveck_caddq_seq_pkg.sv | 15 +
 rtl/polyveck_caddq_seq_if.sv | 30 +++
 rtl/polyveck_caddq_seq_coeff_caddq.sv | 12 +
 rtl/polyveck_caddq_seq.sv | 96 +++++++++
 4 files changed

// File: rtl/polyveck_caddq_seq_pkg.sv
// rtl/polyveck_caddq_seq_pkg.sv - shared constants and state encoding for the caddq stage
package polyveck_caddq_seq_pkg;

   localparam int DILITHIUM_Q = 8380417;
   localparam int DILITHIUM_N = 256;
   localparam int DILITHIUM_K = 6;
   localparam int COEFF_W     = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/polyveck_caddq_seq_if.sv
// rtl/polyveck_caddq_seq_if.sv - start/busy/done handshake and vector buses for the caddq stage
interface polyveck_caddq_seq_if
   import polyveck_caddq_seq_pkg::*;
#(
   parameter int W = DILITHIUM_K * DILITHIUM_N * COEFF_W
);

   logic         start;
   logic         busy;
   logic         done;
   logic [W-1:0] v_in;
   logic [W-1:0] v_out;

   modport master (
      output start,
      output v_in,
      input  busy,
      input  done,
      input  v_out
   );

   modport slave (
      input  start,
      input  v_in,
      output busy,
      output done,
      output v_out
   );

endinterface

// File: rtl/polyveck_caddq_seq_coeff_caddq.sv
// rtl/polyveck_caddq_seq_coeff_caddq.sv - maps one centered coefficient to [0, Q) by adding Q when negative
module coeff_caddq
   import polyveck_caddq_seq_pkg::*;
(
   input  logic [COEFF_W-1:0] a,
   output logic [COEFF_W-1:0] r
);

   // Out-of-range inputs simply wrap in COEFF_W bits.
   assign r = a + (a[COEFF_W-1] ? COEFF_W'(DILITHIUM_Q) : '0);

endmodule

// File: rtl/polyveck_caddq_seq.sv
// rtl/polyveck_caddq_seq.sv - sequential conditional-add-Q over a K-polynomial vector, LANES coefficients per cycle
module polyveck_caddq_seq
   import polyveck_caddq_seq_pkg::*;
#(
   parameter int LANES = 8
)(
   input  logic                clk,
   input  logic                rst,
   polyveck_caddq_seq_if.slave bus
);

   localparam int NCOEF = DILITHIUM_K * DILITHIUM_N;
   localparam int W     = NCOEF * COEFF_W;
   localparam int NGRP  = NCOEF / LANES;
   localparam int GW    = $clog2(NGRP);
   localparam int OW    = $clog2(W);
   localparam logic [GW-1:0] G_LAST = GW'(NGRP - 1);

   state_t        state;
   state_t        state_next;
   logic [GW-1:0] g;
   logic          capture;
   logic          run;
   logic [W-1:0]  work;

   logic [OW-1:0]      lane_off [LANES];
   logic [COEFF_W-1:0] lane_a   [LANES];
   logic [COEFF_W-1:0] lane_r   [LANES];

   always_comb begin
      state_next = state;
      capture    = 1'b0;
      run        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               capture    = 1'b1;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            run = 1'b1;
            if (g == G_LAST) state_next = ST_DONE;
         end
         ST_DONE: begin
            // A start in the done cycle chains straight into the next run.
            if (bus.start) begin
               capture    = 1'b1;
               state_next = ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         g     <= '0;
      end else begin
         state <= state_next;
         if (capture)
            g <= '0;
         else if (run && g != G_LAST)
            g <= g + 1'b1;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_off[l] = OW'((int'(g) * LANES + l) * COEFF_W);
      assign lane_a[l]   = work[lane_off[l] +: COEFF_W];

      coeff_caddq u_caddq (
         .a (lane_a[l]),
         .r (lane_r[l])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         work <= '0;
      end else if (capture) begin
         work <= bus.v_in;
      end else if (run) begin
         for (int l = 0; l < LANES; l++)
            work[lane_off[l] +: COEFF_W] <= lane_r[l];
      end
   end

   assign bus.busy  = (state == ST_RUN);
   assign bus.done  = (state == ST_DONE);
   assign bus.v_out = work;

endmodule
